// File: rtl/bingo_turn_master_pkg.sv
// Shared encodings for the Bingo master board: game states, peer message
// types and the scoring limits used by the turn sequencer.
package bingo_turn_master_pkg;

  typedef enum logic [3:0] {
    GAME_IDLE          = 4'd0,
    GAME_P1_GUESS      = 4'd1,
    GAME_WAIT_P2_GUESS = 4'd2,
    GAME_CHECK         = 4'd3,
    GAME_WIN           = 4'd4,
    GAME_LOSE          = 4'd5
  } game_state_t;

  typedef logic [2:0]  msg_type_t;
  typedef logic [24:0] circle_t;

  localparam msg_type_t SEL_NUM   = 3'd1;
  localparam msg_type_t STATE_WIN = 3'd2;

  localparam logic [4:0] MAX_TURNS = 5'd25;

endpackage

// File: rtl/bingo_turn_master_if.sv
// Signals between the turn master and its neighbours (top-level control,
// guess handler, interboard link).
interface bingo_turn_master_if;
  import bingo_turn_master_pkg::*;

  // Every strobe here is valid-only with no ready: start_game, guess_done,
  // interboard_en, start_guess, clear_guess and send_en are single-cycle
  // pulses consumed on the edge they are high; the receiver is always able
  // to take them, so there is no back-pressure.
  logic       start_game;
  logic       guess_done;
  circle_t    circle;
  logic       interboard_en;
  msg_type_t  interboard_msg_type;

  logic [3:0] cur_game_state;
  logic       start_guess;
  logic       clear_guess;
  logic       send_en;
  msg_type_t  send_msg_type;
  logic [3:0] line_count;
  logic [4:0] turn_count;

  modport master (
    input  start_game, guess_done, circle, interboard_en, interboard_msg_type,
    output cur_game_state, start_guess, clear_guess, send_en, send_msg_type,
           line_count, turn_count
  );

  modport slave (
    output start_game, guess_done, circle, interboard_en, interboard_msg_type,
    input  cur_game_state, start_guess, clear_guess, send_en, send_msg_type,
           line_count, turn_count
  );

endinterface

// File: rtl/bingo_line_counter.sv
// Counts completed lines (5 rows, 5 columns, 2 diagonals) in a 5x5 circle
// map, bit index row*5+col. Purely combinational; shared with the slave board.
module bingo_line_counter
  import bingo_turn_master_pkg::*;
(
  input  circle_t    circle,
  output logic [3:0] lines
);

  logic [3:0] count;
  logic       diag;
  logic       anti_diag;

  always_comb begin
    count = '0;
    for (int r = 0; r < 5; r++) begin
      count = count + {3'b000, &circle[r*5 +: 5]};
    end
    for (int c = 0; c < 5; c++) begin
      count = count + {3'b000, circle[c] & circle[c+5] & circle[c+10] &
                               circle[c+15] & circle[c+20]};
    end
    diag      = circle[0] & circle[6] & circle[12] & circle[18] & circle[24];
    anti_diag = circle[4] & circle[8] & circle[12] & circle[16] & circle[20];
    count     = count + {3'b000, diag} + {3'b000, anti_diag};
  end

  assign lines = count;

endmodule

// File: rtl/bingo_turn_master.sv
// Master-board Bingo sequencer: alternates P1/P2 guesses, scores the circle
// map after each guess and declares win or lose.
module bingo_turn_master
  import bingo_turn_master_pkg::*;
#(
  parameter int WIN_LINES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic interboard_rst,
  bingo_turn_master_if.master bus
);

  game_state_t state;
  logic        last_turn;
  logic        start_guess_q;
  logic        clear_guess_q;
  logic        send_en_q;
  msg_type_t   send_msg_type_q;
  logic [3:0]  line_count_q;
  logic [4:0]  turn_count_q;
  logic [3:0]  lines;
  logic        peer_win;
  logic        start_ok;

  bingo_line_counter u_line_counter (
    .circle (bus.circle),
    .lines  (lines)
  );

  assign peer_win = bus.interboard_en && (bus.interboard_msg_type == STATE_WIN);
  assign start_ok = bus.start_game &&
                    (state == GAME_IDLE || state == GAME_WIN || state == GAME_LOSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= GAME_IDLE;
      last_turn       <= 1'b0;
      start_guess_q   <= 1'b0;
      clear_guess_q   <= 1'b0;
      send_en_q       <= 1'b0;
      send_msg_type_q <= '0;
      line_count_q    <= '0;
      turn_count_q    <= '0;
    end else if (interboard_rst) begin
      // Peer abort: back to power-on values, dropping any pulse scheduled now.
      state           <= GAME_IDLE;
      last_turn       <= 1'b0;
      start_guess_q   <= 1'b0;
      clear_guess_q   <= 1'b0;
      send_en_q       <= 1'b0;
      send_msg_type_q <= '0;
      line_count_q    <= '0;
      turn_count_q    <= '0;
    end else begin
      start_guess_q   <= 1'b0;
      clear_guess_q   <= 1'b0;
      send_en_q       <= 1'b0;
      send_msg_type_q <= '0;
      case (state)
        GAME_IDLE, GAME_WIN, GAME_LOSE: begin
          if (start_ok) begin
            state         <= GAME_P1_GUESS;
            start_guess_q <= 1'b1;
            clear_guess_q <= 1'b1;
            line_count_q  <= '0;
            turn_count_q  <= '0;
          end
        end
        GAME_P1_GUESS: begin
          if (bus.guess_done) begin
            state     <= GAME_CHECK;
            last_turn <= 1'b0;
          end
        end
        GAME_WAIT_P2_GUESS: begin
          if (peer_win) begin
            state <= GAME_LOSE;
          end else if (bus.guess_done) begin
            state     <= GAME_CHECK;
            last_turn <= 1'b1;
          end
        end
        GAME_CHECK: begin
          line_count_q <= lines;
          turn_count_q <= (turn_count_q >= MAX_TURNS) ? MAX_TURNS
                                                      : turn_count_q + 5'd1;
          // Our own bingo wins even when the peer claims one in the same cycle.
          if (lines >= 4'(WIN_LINES)) begin
            state           <= GAME_WIN;
            send_en_q       <= 1'b1;
            send_msg_type_q <= STATE_WIN;
          end else if (peer_win) begin
            state <= GAME_LOSE;
          end else begin
            state         <= last_turn ? GAME_P1_GUESS : GAME_WAIT_P2_GUESS;
            start_guess_q <= 1'b1;
          end
        end
        default: state <= GAME_IDLE;
      endcase
    end
  end

  assign bus.cur_game_state = state;
  assign bus.start_guess    = start_guess_q;
  assign bus.clear_guess    = clear_guess_q;
  assign bus.send_en        = send_en_q;
  assign bus.send_msg_type  = send_msg_type_q;
  assign bus.line_count     = line_count_q;
  assign bus.turn_count     = turn_count_q;

endmodule

// File: tb/tb_bingo_turn_master.sv
// Directed bench for bingo_turn_master: turn flow, scoring, win/lose and resets.
module tb_bingo_turn_master;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_P1   = 4'd1;
  localparam logic [3:0] S_P2   = 4'd2;
  localparam logic [3:0] S_CHK  = 4'd3;
  localparam logic [3:0] S_WIN  = 4'd4;
  localparam logic [3:0] S_LOSE = 4'd5;
  localparam logic [2:0] M_WIN  = 3'd2;

  logic clk;
  logic rst;
  logic interboard_rst;
  int   errors;
  int   checks;

  bingo_turn_master_if bus ();

  bingo_turn_master dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .bus            (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {state, start_guess, clear_guess, send_en, send_msg_type, line_count, turn_count}
  function automatic logic [18:0] outs();
    return {bus.cur_game_state, bus.start_guess, bus.clear_guess, bus.send_en,
            bus.send_msg_type, bus.line_count, bus.turn_count};
  endfunction

  function automatic logic [18:0] exp_outs(logic [3:0] s, logic sg, logic cg,
                                           logic se, logic [2:0] mt,
                                           logic [3:0] lc, logic [4:0] tc);
    return {s, sg, cg, se, mt, lc, tc};
  endfunction

  // driver tasks
  task automatic do_start();
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
  endtask

  task automatic do_guess(input logic [24:0] c);
    bus.circle     = c;
    bus.guess_done = 1'b1;
    tick();
    bus.guess_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] o;
    rst = 1'b1;
    tick();
    tick();
    o = outs();
    checks++;
    if (o !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", o, 19'd0);
    end
    rst = 1'b0;
    tick();
    o = outs();
    checks++;
    if (o !== 19'd0) begin
      errors++;
      $display("FAIL idle_after_reset got=%h exp=%h", o, 19'd0);
    end
  endtask

  task automatic test_start();
    logic [18:0] o;
    logic [18:0] e;
    do_start();
    o = outs();
    e = exp_outs(S_P1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 5'd0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL start_pulse got=%h exp=%h", o, e);
    end
    tick();
    o = outs();
    e = exp_outs(S_P1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 5'd0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL start_pulse_len got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_p1_ignores();
    logic [18:0] o;
    logic [18:0] e;
    bus.interboard_en       = 1'b1;
    bus.interboard_msg_type = M_WIN;
    bus.start_game          = 1'b1;
    tick();
    bus.interboard_en       = 1'b0;
    bus.interboard_msg_type = 3'd0;
    bus.start_game          = 1'b0;
    o = outs();
    e = exp_outs(S_P1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 5'd0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL p1_ignores_peer_and_start got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_p1_row();
    logic [18:0] o;
    logic [18:0] e;
    do_guess(25'h000001F);
    checks++;
    if (bus.cur_game_state !== S_CHK) begin
      errors++;
      $display("FAIL p1_check_state got=%0d exp=%0d", bus.cur_game_state, S_CHK);
    end
    tick();
    o = outs();
    e = exp_outs(S_P2, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1, 5'd1);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL p1_row_score got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_p2_win();
    logic [18:0] o;
    logic [18:0] e;
    do_guess(25'h1FFFFFF);
    tick();
    o = outs();
    e = exp_outs(S_WIN, 1'b0, 1'b0, 1'b1, M_WIN, 4'd12, 5'd2);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL p2_full_win got=%h exp=%h", o, e);
    end
    tick();
    o = outs();
    e = exp_outs(S_WIN, 1'b0, 1'b0, 1'b0, 3'd0, 4'd12, 5'd2);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL win_hold_send_len got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_lose_priority();
    logic [18:0] o;
    logic [18:0] e;
    do_start();
    do_guess(25'h000001F);
    tick();
    bus.interboard_en       = 1'b1;
    bus.interboard_msg_type = M_WIN;
    do_guess(25'h1FFFFFF);
    bus.interboard_en       = 1'b0;
    bus.interboard_msg_type = 3'd0;
    o = outs();
    e = exp_outs(S_LOSE, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1, 5'd1);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL peer_win_over_guess got=%h exp=%h", o, e);
    end
    tick();
    o = outs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL lose_hold got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_check_peer_win();
    logic [18:0] o;
    logic [18:0] e;
    do_start();
    do_guess(25'h0000000);
    bus.interboard_en       = 1'b1;
    bus.interboard_msg_type = M_WIN;
    tick();
    bus.interboard_en       = 1'b0;
    bus.interboard_msg_type = 3'd0;
    o = outs();
    e = exp_outs(S_LOSE, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 5'd1);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL check_peer_win got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_win_boundary();
    logic [18:0] o;
    logic [18:0] e;
    do_start();
    do_guess(25'h00FFFFF);
    tick();
    o = outs();
    e = exp_outs(S_P2, 1'b1, 1'b0, 1'b0, 3'd0, 4'd4, 5'd1);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL four_lines_continue got=%h exp=%h", o, e);
    end
    do_guess(25'h04FFFFF);
    tick();
    o = outs();
    e = exp_outs(S_WIN, 1'b0, 1'b0, 1'b1, M_WIN, 4'd5, 5'd2);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL five_lines_win got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_saturate();
    logic [18:0] o;
    logic [18:0] e;
    logic [4:0]  exp_turn;
    logic [3:0]  exp_state;
    do_start();
    for (int i = 0; i < 26; i++) begin
      do_guess(25'h10413E1);
      checks++;
      if (bus.cur_game_state !== S_CHK) begin
        errors++;
        $display("FAIL sat_check_state i=%0d got=%0d exp=%0d", i, bus.cur_game_state, S_CHK);
      end
      tick();
      exp_turn  = (i + 1 > 25) ? 5'd25 : 5'(i + 1);
      exp_state = (i % 2 == 0) ? S_P2 : S_P1;
      o = outs();
      e = exp_outs(exp_state, 1'b1, 1'b0, 1'b0, 3'd0, 4'd2, exp_turn);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sat_turn i=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_interboard_rst();
    logic [18:0] o;
    do_start();
    tick();
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    o = outs();
    checks++;
    if (o !== 19'd0) begin
      errors++;
      $display("FAIL ib_rst_p1 got=%h exp=%h", o, 19'd0);
    end
    interboard_rst = 1'b1;
    do_start();
    interboard_rst = 1'b0;
    o = outs();
    checks++;
    if (o !== 19'd0) begin
      errors++;
      $display("FAIL ib_rst_drops_start got=%h exp=%h", o, 19'd0);
    end
  endtask

  task automatic test_async_rst();
    logic [18:0] o;
    do_start();
    do_guess(25'h000001F);
    tick();
    do_guess(25'h0000000);
    checks++;
    if ({bus.cur_game_state, bus.line_count, bus.turn_count} !== {S_CHK, 4'd1, 5'd1}) begin
      errors++;
      $display("FAIL pre_async_check got=%h exp=%h",
               {bus.cur_game_state, bus.line_count, bus.turn_count}, {S_CHK, 4'd1, 5'd1});
    end
    #2;
    rst = 1'b1;
    #1;
    o = outs();
    checks++;
    if (o !== 19'd0) begin
      errors++;
      $display("FAIL async_rst_mid_check got=%h exp=%h", o, 19'd0);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    errors                  = 0;
    checks                  = 0;
    rst                     = 1'b1;
    interboard_rst          = 1'b0;
    bus.start_game          = 1'b0;
    bus.guess_done          = 1'b0;
    bus.circle              = '0;
    bus.interboard_en       = 1'b0;
    bus.interboard_msg_type = 3'd0;
    test_reset();
    test_start();
    test_p1_ignores();
    test_p1_row();
    test_p2_win();
    test_lose_priority();
    test_check_peer_win();
    test_win_boundary();
    test_saturate();
    test_interboard_rst();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
